// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : stopwatch_pkg
// Brief  : Shared widths, digit map, FSM encoding and 7-segment patterns
//          for the stopwatch display path.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int HOURS_W      = 4;
    localparam int MIN_W        = 6;
    localparam int SEC_W        = 6;
    localparam int MS_W         = 10;
    localparam int CVT_W        = 10;
    localparam int SHIFT_CYCLES = 10;

    // Digit positions, 7 = leftmost
    localparam logic [2:0] DIG_MS_T  = 3'd0;
    localparam logic [2:0] DIG_MS_H  = 3'd1;
    localparam logic [2:0] DIG_SEC_U = 3'd2;
    localparam logic [2:0] DIG_SEC_T = 3'd3;
    localparam logic [2:0] DIG_MIN_U = 3'd4;
    localparam logic [2:0] DIG_MIN_T = 3'd5;
    localparam logic [2:0] DIG_HR_U  = 3'd6;
    localparam logic [2:0] DIG_HR_T  = 3'd7;

    localparam logic [1:0] FLD_HOURS = 2'd0;
    localparam logic [1:0] FLD_MIN   = 2'd1;
    localparam logic [1:0] FLD_SEC   = 2'd2;
    localparam logic [1:0] FLD_MS    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_STORE  = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    // Active-low gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bin2bcd_seq
// Brief  : 10-bit iterative double-dabble, one bit per clock after start.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    logic [9:0]  r_bin;
    logic [11:0] r_bcd;
    logic [3:0]  r_step;
    logic        r_busy;
    logic        r_done;
    logic [10:0] w_adj;

    // Top nibble is left unadjusted so it carries floor(bin/100) in binary (0..10)
    always_comb begin
        w_adj = r_bcd[10:0];
        if (r_bcd[3:0] >= 4'd5) w_adj[3:0] = r_bcd[3:0] + 4'd3;
        if (r_bcd[7:4] >= 4'd5) w_adj[7:4] = r_bcd[7:4] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_step <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bin  <= bin;
                r_bcd  <= '0;
                r_step <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bcd  <= {w_adj, r_bin[9]};
                r_bin  <= {r_bin[8:0], 1'b0};
                r_step <= r_step + 4'd1;
                if (r_step == 4'(SHIFT_CYCLES - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : stopwatch_display
// Brief  : Snapshots the time bus, converts each field to BCD through one
//          shared converter and scans HH.MM.SS.cc on 8 common-anode digits.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int SAMPLE_DIV = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [HOURS_W-1:0] hours,
    input  logic [MIN_W-1:0]   minutes,
    input  logic [SEC_W-1:0]   seconds,
    input  logic [MS_W-1:0]    milliseconds,
    input  logic               hold,
    output logic [7:0]         an,
    output logic [6:0]         seg,
    output logic               dp,
    output logic               busy,
    output logic               frame_done
);

    localparam int SAMPLE_W = $clog2(SAMPLE_DIV);
    localparam int SCAN_W   = $clog2(SCAN_DIV);

    logic [SAMPLE_W-1:0] r_sample_cnt;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [2:0]          r_idx;
    state_e              r_state;
    state_e              w_state_nxt;
    logic [1:0]          r_field;
    logic [3:0]          r_shift_cnt;
    logic [HOURS_W-1:0]  r_snap_hours;
    logic [MIN_W-1:0]    r_snap_min;
    logic [SEC_W-1:0]    r_snap_sec;
    logic [MS_W-1:0]     r_snap_ms;
    logic [3:0]          r_stage [8];
    logic [3:0]          r_disp  [8];
    logic [7:0]          r_an;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic                r_frame_done;

    logic                w_sample_tick;
    logic                w_take;
    logic                w_cvt_start;
    logic                w_cvt_busy;
    logic                w_cvt_done;
    logic [CVT_W-1:0]    w_cvt_bin;
    logic [11:0]         w_cvt_bcd;
    logic [3:0]          w_ms_hund;
    logic [7:0]          w_an_nxt;
    logic [6:0]          w_seg_nxt;
    logic                w_dp_nxt;
    logic                w_unused_cvt_busy;

    assign w_sample_tick     = (r_sample_cnt == SAMPLE_W'(SAMPLE_DIV - 1));
    assign w_take            = w_sample_tick && (r_state == ST_IDLE) && !hold;
    assign w_unused_cvt_busy = w_cvt_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample_cnt <= '0;
            r_scan_cnt   <= '0;
            r_idx        <= '0;
        end else begin
            r_sample_cnt <= w_sample_tick ? '0 : r_sample_cnt + SAMPLE_W'(1);
            if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cvt_start = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_take) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_cvt_start = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT:  if (r_shift_cnt == 4'(SHIFT_CYCLES - 1)) w_state_nxt = ST_STORE;
            ST_STORE:  w_state_nxt = (r_field == FLD_MS) ? ST_COMMIT : ST_LOAD;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        case (r_field)
            FLD_HOURS: w_cvt_bin = {{(CVT_W - HOURS_W){1'b0}}, r_snap_hours};
            FLD_MIN:   w_cvt_bin = {{(CVT_W - MIN_W){1'b0}}, r_snap_min};
            FLD_SEC:   w_cvt_bin = {{(CVT_W - SEC_W){1'b0}}, r_snap_sec};
            default:   w_cvt_bin = r_snap_ms;
        endcase
    end

    // 1000..1023 yields a hundreds nibble of 10; show it modulo 10
    assign w_ms_hund = (w_cvt_bcd[11:8] >= 4'd10) ? w_cvt_bcd[11:8] - 4'd10 : w_cvt_bcd[11:8];

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_cvt_start),
        .bin   (w_cvt_bin),
        .busy  (w_cvt_busy),
        .done  (w_cvt_done),
        .bcd   (w_cvt_bcd)
    );

    // Digits accumulate in r_stage and move to r_disp together so a frame never tears
    always_ff @(posedge clk) begin
        if (reset) begin
            r_field      <= FLD_HOURS;
            r_shift_cnt  <= '0;
            r_snap_hours <= '0;
            r_snap_min   <= '0;
            r_snap_sec   <= '0;
            r_snap_ms    <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_stage[i] <= '0;
                r_disp[i]  <= '0;
            end
        end else begin
            r_frame_done <= (r_state == ST_COMMIT);
            if (w_take) begin
                r_snap_hours <= hours;
                r_snap_min   <= minutes;
                r_snap_sec   <= seconds;
                r_snap_ms    <= milliseconds;
                r_field      <= FLD_HOURS;
            end
            if (r_state == ST_LOAD)       r_shift_cnt <= '0;
            else if (r_state == ST_SHIFT) r_shift_cnt <= r_shift_cnt + 4'd1;
            if (r_state == ST_STORE) begin
                r_field <= r_field + 2'd1;
                if (w_cvt_done) begin
                    case (r_field)
                        FLD_HOURS: begin
                            r_stage[DIG_HR_T] <= w_cvt_bcd[7:4];
                            r_stage[DIG_HR_U] <= w_cvt_bcd[3:0];
                        end
                        FLD_MIN: begin
                            r_stage[DIG_MIN_T] <= w_cvt_bcd[7:4];
                            r_stage[DIG_MIN_U] <= w_cvt_bcd[3:0];
                        end
                        FLD_SEC: begin
                            r_stage[DIG_SEC_T] <= w_cvt_bcd[7:4];
                            r_stage[DIG_SEC_U] <= w_cvt_bcd[3:0];
                        end
                        default: begin
                            r_stage[DIG_MS_H] <= w_ms_hund;
                            r_stage[DIG_MS_T] <= w_cvt_bcd[7:4];
                        end
                    endcase
                end
            end
            if (r_state == ST_COMMIT) r_disp <= r_stage;
        end
    end

    always_comb begin
        w_an_nxt  = ~(8'b0000_0001 << r_idx);
        w_seg_nxt = seg_encode(r_disp[r_idx]);
        if (r_idx == DIG_HR_T && r_disp[DIG_HR_T] == 4'd0) w_seg_nxt = SEG_BLANK;
        w_dp_nxt  = !(r_idx == DIG_HR_U || r_idx == DIG_MIN_U || r_idx == DIG_SEC_U);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 8'hFE;
            r_seg <= SEG_0;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
